// File: rtl/types_kem_pkg.sv
// types_kem: shared ML-KEM polynomial types, constants and the encoder FSM state type.
package types_kem;
  localparam int KYBER_Q = 3329;
  localparam int ENC12_WORDS = 48;
  typedef logic [11:0] coeff12_t;
  typedef coeff12_t [255:0] poly12_t;
  typedef enum logic {IDLE, PACK} enc_state_t;
endpackage

// File: rtl/poly_enc_gearbox.sv
// poly_enc_gearbox: IN_W-bit load / WORD_W-bit pop accumulator with fill tracking.
module poly_enc_gearbox #(
  parameter int IN_W = 48,
  parameter int WORD_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              pop_i,
  input  logic              load_i,
  input  logic [IN_W-1:0]   din_i,
  output logic [WORD_W-1:0] word_o,
  output logic              have_word_o,
  output logic              room_o
);
  localparam int ACC_W = IN_W + WORD_W;
  localparam logic [7:0] IN_F = 8'(IN_W);
  localparam logic [7:0] WORD_F = 8'(WORD_W);
  localparam logic [7:0] ACC_F = 8'(ACC_W);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0] fill_q, fill_d, f1;
  // bits above fill are always zero, so a load can simply OR in at offset f1
  always_comb begin
    f1 = fill_q - (pop_i ? WORD_F : 8'd0);
    room_o = f1 + IN_F <= ACC_F;
    acc_d = clr_i ? '0 : (pop_i ? acc_q >> WORD_W : acc_q) | (load_i ? ACC_W'(din_i) << f1 : '0);
    fill_d = clr_i ? '0 : f1 + (load_i ? IN_F : 8'd0);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      fill_q <= '0;
    end else begin
      acc_q <= acc_d;
      fill_q <= fill_d;
    end
  end
  assign word_o = acc_q[WORD_W-1:0];
  assign have_word_o = fill_q >= WORD_F;
endmodule

// File: rtl/poly_byte_encode.sv
// poly_byte_encode: ByteEncode_12 of one polynomial into 48 x 64-bit words over valid/ready.
// Optional POLY_ENC_CANON_EN folds coefficients >= KYBER_Q down by KYBER_Q before packing.
module poly_byte_encode import types_kem::*; #(
  parameter int IN_COEFFS = 4,
  parameter int WORD_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  poly12_t           poly_i,
  output logic              busy_o,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              done_o
);
  localparam int IN_W = IN_COEFFS * 12;
  localparam int NGRP = 256 / IN_COEFFS;
  enc_state_t state_q, state_d;
  poly12_t poly_q, poly_d;
  logic [6:0] grp_q, grp_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic start, pop, load, last, have_word, room;
  logic [IN_W-1:0] din;
  function automatic coeff12_t canon(input coeff12_t c);
`ifdef POLY_ENC_CANON_EN
    return (c >= 12'(KYBER_Q)) ? c - 12'(KYBER_Q) : c;
`else
    return c;
`endif
  endfunction
  always_comb begin
    start = state_q == IDLE && run_i;
    valid_o = state_q == PACK && have_word;
    pop = valid_o && ready_i;
    load = state_q == PACK && grp_q < 7'(NGRP) && room;
    last = pop && wcnt_q == 6'(ENC12_WORDS - 1);
    din = '0;
    for (int k = 0; k < IN_COEFFS; k++)
      din[12*k +: 12] = canon(poly_q[IN_COEFFS * int'(grp_q[5:0]) + k]);
    state_d = state_q == IDLE ? (run_i ? PACK : IDLE) : (last ? IDLE : PACK);
    poly_d = start ? poly_i : poly_q;
    grp_d = start ? '0 : grp_q + 7'(load);
    wcnt_d = start ? '0 : wcnt_q + 6'(pop);
    busy_d = start || (busy_q && !last);
    done_d = last;
  end
  always_ff @(posedge clk_i) begin
    poly_q <= poly_d;
    if (rst_i) begin
      state_q <= IDLE;
      grp_q <= '0;
      wcnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q <= grp_d;
      wcnt_q <= wcnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  poly_enc_gearbox #(.IN_W(IN_W), .WORD_W(WORD_W)) u_gearbox (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(start),
    .pop_i(pop),
    .load_i(load),
    .din_i(din),
    .word_o(word_o),
    .have_word_o(have_word),
    .room_o(room)
  );
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule
